memoria_dados_ctrl: RTL
=======================

MEMORIA_DADOS_CTRL -- requirements
Module: memoria_dados_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: word-address bits; depth is 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter WAIT_STATES, default 1: extra cycles inserted before each access, range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  1  request strobe; sampled only while busy=0.
REQ-006 we  input  1  1 = store, 0 = load.
REQ-007 size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 sign_ext  input  1  loads only: 1 = sign-extend sub-word data, 0 = zero-extend.
REQ-009 addr  input  ADDR_WIDTH+2  byte address.
REQ-010 wdata  input  32  store data, right-justified for byte/halfword.
REQ-011 busy  output  1  high from acceptance until the cycle ready is asserted.
REQ-012 ready  output  1  one-cycle completion pulse.
REQ-013 rdata  output  32  registered load result; valid while ready=1, held until the next completion.
REQ-014 err  output  1  valid with ready: 1 = misaligned or reserved size.

Function
REQ-015 States SHALL be IDLE, WAIT, ACCESS and RESP.
REQ-016 IDLE with req=1 SHALL latch we, size, sign_ext, addr and wdata, assert busy, and go to WAIT; with WAIT_STATES=0 it SHALL go directly to ACCESS.
REQ-017 WAIT SHALL count WAIT_STATES cycles, then go to ACCESS.
REQ-018 ACCESS SHALL perform the array read or write, then go to RESP.
REQ-019 RESP SHALL assert ready for exactly one cycle, deassert busy in that same cycle, and return to IDLE.
REQ-020 Latency from the acceptance edge to ready SHALL be WAIT_STATES+2 cycles.
REQ-021 req asserted while busy=1 SHALL be ignored; there is no queuing.
REQ-022 A new req SHALL be accepted in the cycle after ready.
REQ-023 Lane mapping SHALL be little-endian: byte lane addr[1:0] occupies bits 8*addr[1:0]+7 : 8*addr[1:0].
REQ-024 Word index SHALL be addr[ADDR_WIDTH+1:2]; there is no range check.
REQ-025 Byte store SHALL write only lane addr[1:0] with wdata[7:0].
REQ-026 Halfword store SHALL write lanes addr[1]*2 and addr[1]*2+1 with wdata[15:0].
REQ-027 Word store SHALL write all four lanes.
REQ-028 Unselected lanes SHALL be unchanged on every store.
REQ-029 Sub-word loads SHALL right-justify the selected lanes and extend them per sign_ext; word loads SHALL ignore sign_ext.
REQ-030 A halfword with addr[0]=1, a word with addr[1:0]!=0, or size=11 SHALL be flagged as an error.
REQ-031 An error request SHALL skip WAIT and ACCESS, go directly to RESP, respond with err=1 and rdata=0, and leave memory unmodified.
REQ-032 Stores SHALL respond with err=0 and leave rdata unchanged.
REQ-033 A load issued immediately after a store to the same word SHALL return the newly written data.

Reset
REQ-034 While rst=1: state SHALL go to IDLE, the wait counter to 0, and busy, ready, err and rdata to 0.
REQ-035 Memory contents SHALL NOT be cleared by reset.
REQ-036 Reset asserted in WAIT or ACCESS SHALL abort the pending transaction; a store aborted before its ACCESS edge SHALL NOT write.
REQ-037 req SHALL be ignored in the cycle rst=1.

Structure
REQ-038 Package memoria_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state enumeration and the lane-enable width constant.
REQ-039 Sub-module memoria_banco SHALL implement a single-port, byte-enabled synchronous RAM (4 lane enables, registered read).
REQ-040 The top level SHALL contain the FSM, wait counter, lane steering and extension logic.

Verification
REQ-041 Word round trip, WAIT_STATES=1: sw 0xDEADBEEF to addr 0x010, then lw 0x010 -> ready 3 cycles after acceptance, rdata=0xDEADBEEF, err=0.
REQ-042 Byte stores: after REQ-041, sb 0x7F to 0x011 and sb 0x80 to 0x013; lw 0x010 -> 0x80AD7FEF; lb sign_ext=1 at 0x013 -> 0xFFFFFF80; lbu at 0x013 -> 0x00000080.
REQ-043 Halfword: sh 0x8001 to 0x022, then lh 0x022 -> 0xFFFF8001 and lhu -> 0x00008001; word 0x020 lanes 0-1 unchanged.
REQ-044 Misaligned: sw to 0x031 -> ready next-but-one cycle, err=1, lw 0x030 unchanged; size=11 -> err=1.
REQ-045 Busy and reset: req during busy is ignored (exactly one ready); rst asserted in WAIT of sw 0x12345678 to 0x040 -> outputs 0, later lw 0x040 returns the prior value.
REQ-046 WAIT_STATES=0 and 5: ready latency is 2 and 7 cycles respectively; back-to-back requests are issued the cycle after ready.

Source files
------------

// File: rtl/memoria_pkg.sv
// rtl/memoria_pkg.sv - shared encodings for the data memory controller
//
// Purpose: access-size encodings, FSM state encodings, lane count and the
//          small decode helpers used by memoria_dados_ctrl and memoria_banco.
// Ports:   none (package).
package memoria_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam int LANES = 4;

  // Misaligned halfword/word or the reserved size encoding.
  function automatic logic f_bad_access(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: f_bad_access = 1'b0;
      SZ_HALF: f_bad_access = lo[0];
      SZ_WORD: f_bad_access = (lo != 2'b00);
      default: f_bad_access = 1'b1;
    endcase
  endfunction

  // Little-endian lane enables for a store of the given size.
  function automatic logic [LANES-1:0] f_lane_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: f_lane_en = 4'b0001 << lo;
      SZ_HALF: f_lane_en = lo[1] ? 4'b1100 : 4'b0011;
      default: f_lane_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/memoria_banco.sv
// rtl/memoria_banco.sv - single-port byte-enabled synchronous RAM
//
// Purpose: 2**ADDR_WIDTH x 32-bit storage with per-lane write enables and a
//          registered read port. Contents are never reset.
// Ports:   i_clk    clock
//          i_en     access enable for this cycle
//          i_we     1 = write lanes selected by i_be, 0 = read into o_rdata
//          i_be     lane enables, bit n covers bits 8n+7:8n
//          i_addr   word index
//          i_wdata  write data, already steered to its lanes
//          o_rdata  read data, valid the cycle after a read access
module memoria_banco
  import memoria_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [LANES-1:0]      i_be,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int l = 0; l < LANES; l++) begin
          if (i_be[l]) r_mem[i_addr][8*l +: 8] <= i_wdata[8*l +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/memoria_dados_ctrl.sv
// rtl/memoria_dados_ctrl.sv - wait-stated byte/halfword/word data memory controller
//
// Purpose: accepts one load/store at a time, inserts WAIT_STATES cycles, performs
//          the access on memoria_banco and returns a one-cycle ready pulse with
//          right-justified, optionally sign-extended load data.
// Ports:   i_clk, i_rst      clock, synchronous active-high reset
//          i_req             request strobe, sampled only while o_busy=0
//          i_we              1 = store, 0 = load
//          i_size            00 byte, 01 halfword, 10 word, 11 reserved
//          i_sign_ext        sub-word loads: 1 = sign-extend, 0 = zero-extend
//          i_addr            byte address
//          i_wdata           store data, right-justified
//          o_busy            high from acceptance until ready
//          o_ready           one-cycle completion pulse
//          o_rdata           load result, held until the next completion
//          o_err             with ready: misaligned or reserved size
module memoria_dados_ctrl
  import memoria_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_sign_ext,
  input  logic [ADDR_WIDTH+1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_busy,
  output logic                  o_ready,
  output logic [31:0]           o_rdata,
  output logic                  o_err
);

  // Only reached when WAIT_STATES > 0; the WAIT state is skipped otherwise.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

  logic [1:0]            r_state;
  logic [3:0]            r_wait_cnt;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_sign_ext;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_bad;
  logic                  r_busy;
  logic                  r_ready;
  logic                  r_err;
  logic [31:0]           r_rdata;

  logic                  w_accept;
  logic                  w_bad_in;
  logic                  w_ram_en;
  logic [LANES-1:0]      w_be;
  logic [31:0]           w_ram_wdata;
  logic [31:0]           w_ram_rdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load_data;

  assign w_accept = (r_state == ST_IDLE) && i_req;
  assign w_bad_in = f_bad_access(i_size, i_addr[1:0]);

  // Gating with i_rst keeps a store whose ACCESS edge coincides with reset from writing.
  assign w_ram_en = (r_state == ST_ACCESS) && !i_rst;
  assign w_be     = f_lane_en(r_size, r_addr[1:0]);

  // Replicate sub-word data across lanes; the lane enables pick the right copy.
  always_comb begin
    w_ram_wdata = r_wdata;
    case (r_size)
      SZ_BYTE: w_ram_wdata = {4{r_wdata[7:0]}};
      SZ_HALF: w_ram_wdata = {2{r_wdata[15:0]}};
      default: w_ram_wdata = r_wdata;
    endcase
  end

  memoria_banco #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_banco (
    .i_clk  (i_clk),
    .i_en   (w_ram_en),
    .i_we   (r_we),
    .i_be   (w_be),
    .i_addr (r_addr[ADDR_WIDTH+1:2]),
    .i_wdata(w_ram_wdata),
    .o_rdata(w_ram_rdata)
  );

  assign w_byte = w_ram_rdata[8*r_addr[1:0] +: 8];
  assign w_half = r_addr[1] ? w_ram_rdata[31:16] : w_ram_rdata[15:0];

  always_comb begin
    w_load_data = w_ram_rdata;
    case (r_size)
      SZ_BYTE: w_load_data = {{24{r_sign_ext & w_byte[7]}}, w_byte};
      SZ_HALF: w_load_data = {{16{r_sign_ext & w_half[15]}}, w_half};
      default: w_load_data = w_ram_rdata;
    endcase
  end

  // Request attributes are held for the whole transaction; no reset needed.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_accept) begin
      r_we       <= i_we;
      r_size     <= i_size;
      r_sign_ext <= i_sign_ext;
      r_addr     <= i_addr;
      r_wdata    <= i_wdata;
      r_bad      <= w_bad_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= 32'd0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_busy     <= 1'b1;
            r_wait_cnt <= 4'd0;
            if (w_bad_in)             r_state <= ST_RESP;
            else if (WAIT_STATES == 0) r_state <= ST_ACCESS;
            else                      r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == WAIT_LAST) r_state <= ST_ACCESS;
          else                         r_wait_cnt <= r_wait_cnt + 4'd1;
        end
        ST_ACCESS: r_state <= ST_RESP;
        ST_RESP: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_err   <= r_bad;
          if (r_bad)     r_rdata <= 32'd0;
          else if (!r_we) r_rdata <= w_load_data;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_ready = r_ready;
  assign o_rdata = r_rdata;
  assign o_err   = r_err;

endmodule
